// File: rtl/rv_regfile_sb_if.sv
// Bus bundle for rv_regfile_sb: writeback, two read ports and scoreboard issue/status.
interface rv_regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            we;
  logic [AW-1:0]   addr_d;
  logic [XLEN-1:0] data_d;
  logic [AW-1:0]   addr_a;
  logic [AW-1:0]   addr_b;
  logic [XLEN-1:0] data_a;
  logic [XLEN-1:0] data_b;
  logic            iss_v;
  logic [AW-1:0]   iss_rd;
  logic            busy_a;
  logic            busy_b;

  modport master (
    output we, addr_d, data_d, addr_a, addr_b, iss_v, iss_rd,
    input  data_a, data_b, busy_a, busy_b
  );

  modport slave (
    input  we, addr_d, data_d, addr_a, addr_b, iss_v, iss_rd,
    output data_a, data_b, busy_a, busy_b
  );
endinterface

// File: rtl/rv_regfile_sb.sv
// RISC-V integer register file (x0 hardwired to zero) with a per-register pending-write scoreboard.
// Define RV_REGFILE_BYPASS_EN to forward same-cycle writeback data/busy onto the read ports.
module rv_regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input logic           clk,
  input logic           rst,
  rv_regfile_sb_if.slave bus
);

  logic [XLEN-1:0] regs_q [NREG-1:1];
  logic [XLEN-1:0] regs_d [NREG-1:1];
  logic [NREG-1:1] busy_q;
  logic [NREG-1:1] busy_d;
  logic            wr_ok;
  logic            iss_ok;

  // x0 and out-of-range addresses have no storage behind them.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  function automatic logic [XLEN-1:0] rd_data(input logic [AW-1:0] a);
    return addr_ok(a) ? regs_q[a] : '0;
  endfunction

  function automatic logic rd_busy(input logic [AW-1:0] a);
    return addr_ok(a) ? busy_q[a] : 1'b0;
  endfunction

  always_comb begin
    wr_ok  = bus.we && addr_ok(bus.addr_d);
    iss_ok = bus.iss_v && addr_ok(bus.iss_rd);
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[bus.addr_d] = bus.data_d;
      busy_d[bus.addr_d] = 1'b0;
    end
    // Applied after the clear: a new issue to the register being written back stays pending.
    if (iss_ok) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    bus.data_a = rd_data(bus.addr_a);
    bus.busy_a = rd_busy(bus.addr_a);
`ifdef RV_REGFILE_BYPASS_EN
    // Gated by rst so the forward path cannot leak data while reset holds the outputs at zero.
    if (rst && wr_ok && (bus.addr_d == bus.addr_a)) begin
      bus.data_a = bus.data_d;
      bus.busy_a = iss_ok && (bus.iss_rd == bus.addr_a);
    end
`endif
  end

  always_comb begin
    bus.data_b = rd_data(bus.addr_b);
    bus.busy_b = rd_busy(bus.addr_b);
`ifdef RV_REGFILE_BYPASS_EN
    if (rst && wr_ok && (bus.addr_d == bus.addr_b)) begin
      bus.data_b = bus.data_d;
      bus.busy_b = iss_ok && (bus.iss_rd == bus.addr_b);
    end
`endif
  end

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Self-checking bench for rv_regfile_sb: directed scenarios plus random traffic against an array model.
module tb_rv_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
`ifdef RV_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [XLEN-1:0] mreg  [NREG];
  logic            mbusy [NREG];

  rv_regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

  rv_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      mreg[i]  = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  // Expected read value for the inputs currently on the bus.
  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (BYP && bus.we && bus.addr_d != 0 && bus.addr_d == a) return bus.data_d;
    if (a == 0) return '0;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (BYP && bus.we && bus.addr_d != 0 && bus.addr_d == a)
      return bus.iss_v && bus.iss_rd == a;
    if (a == 0) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic drive(input logic we, input logic [AW-1:0] ad, input logic [XLEN-1:0] dd,
                       input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                       input logic iv, input logic [AW-1:0] ir);
    bus.we = we; bus.addr_d = ad; bus.data_d = dd;
    bus.addr_a = aa; bus.addr_b = ab;
    bus.iss_v = iv; bus.iss_rd = ir;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_da"}, bus.data_a, '0);
    chk({tag, "_db"}, bus.data_b, '0);
    chk({tag, "_ba"}, {31'b0, bus.busy_a}, '0);
    chk({tag, "_bb"}, {31'b0, bus.busy_b}, '0);
  endtask

  // One clock: drive, check combinational reads mid-cycle, then commit the model at the edge.
  task automatic step(input string tag, input logic we, input logic [AW-1:0] ad,
                      input logic [XLEN-1:0] dd, input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                      input logic iv, input logic [AW-1:0] ir);
    drive(we, ad, dd, aa, ab, iv, ir);
    @(negedge clk);
    chk({tag, "_da"}, bus.data_a, exp_data(aa));
    chk({tag, "_db"}, bus.data_b, exp_data(ab));
    chk({tag, "_ba"}, {31'b0, bus.busy_a}, {31'b0, exp_busy(aa)});
    chk({tag, "_bb"}, {31'b0, bus.busy_b}, {31'b0, exp_busy(ab)});
    @(posedge clk);
    if (we && ad != 0) begin
      mreg[ad]  = dd;
      mbusy[ad] = 1'b0;
    end
    if (iv && ir != 0) mbusy[ir] = 1'b1;
    #1;
  endtask

  initial begin
    logic [AW-1:0] ra;
    rst = 1'b0;
    model_reset();
    drive(1'b0, '0, '0, '0, '0, 1'b0, '0);

    // Reset held with random traffic, including write address aimed at read port A.
    for (int i = 0; i < 6; i++) begin
      ra = AW'($urandom);
      drive(1'b1, ra, $urandom, ra, AW'($urandom), 1'b1, ra);
      @(negedge clk);
      check_zero("rst_hold");
      @(posedge clk);
      #1;
    end
    rst = 1'b1;

    for (int i = 1; i < NREG; i++) step("post_rst", 1'b0, '0, '0, AW'(i), AW'(NREG - i), 1'b0, '0);

    step("wr5",   1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, '0);
    step("rd5",   1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b0, '0);
    chk("rd5_const", bus.data_a, 32'hDEADBEEF);
    step("wr0",   1'b1, 5'd0, 32'h1,        5'd0, 5'd5, 1'b1, 5'd0);
    step("rd0",   1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, '0);
    chk("rd0_const", bus.data_a, 32'h0);

    step("iss7",  1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b1, 5'd7);
    step("busy7", 1'b1, 5'd7, 32'h77,       5'd7, 5'd6, 1'b0, '0);
    step("clr7",  1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b0, '0);
    chk("clr7_const", {31'b0, bus.busy_a}, 32'h0);

    step("iss9",  1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b1, 5'd9);
    step("col9",  1'b1, 5'd9, 32'h99AA,     5'd9, 5'd9, 1'b1, 5'd9);
    step("chk9",  1'b1, 5'd10, 32'h1010,    5'd9, 5'd10, 1'b1, 5'd11);
    chk("col9_busy", {31'b0, bus.busy_a}, 32'h1);
    chk("col9_data", bus.data_a, 32'h99AA);

    step("wr3",   1'b1, 5'd3, 32'h11,       5'd0, 5'd0, 1'b0, '0);
    step("byp3",  1'b1, 5'd3, 32'h22,       5'd3, 5'd3, 1'b0, '0);
    step("nxt3",  1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 1'b0, '0);
    chk("nxt3_const", bus.data_a, 32'h22);

    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom), AW'($urandom), $urandom, AW'($urandom), AW'($urandom),
           1'($urandom), AW'($urandom));
    end

    // Asynchronous reset landing between edges during a write/issue to x12.
    step("pre12", 1'b1, 5'd12, 32'hA5A5A5A5, 5'd0, 5'd0, 1'b0, '0);
    drive(1'b1, 5'd12, 32'h5A5A5A5A, 5'd12, 5'd12, 1'b1, 5'd12);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("async_hold");
    rst = 1'b1;
    step("post12", 1'b0, 5'd0, 32'h0, 5'd12, 5'd12, 1'b0, '0);
    chk("post12_const", bus.data_a, 32'h0);
    step("first_wr", 1'b1, 5'd12, 32'hC0FFEE, 5'd1, 5'd2, 1'b1, 5'd13);
    step("first_rd", 1'b0, 5'd0, 32'h0, 5'd12, 5'd13, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rv_regfile_sb.md
RV_REGFILE_SB -- requirements
Module: rv_regfile_sb

Interface
REQ-001 XLEN, 32, register data width in bits.
REQ-002 NREG, 32, number of architectural registers; x0 included.
REQ-003 AW, 5, register address width; SHALL satisfy 2^AW >= NREG.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 we  input  1  write enable, writeback stage.
REQ-007 addr_d  input  AW  write address.
REQ-008 data_d  input  XLEN  write data.
REQ-009 addr_a, addr_b  input  AW each  read addresses, ports A and B.
REQ-010 data_a, data_b  output  XLEN each  read data, ports A and B.
REQ-011 iss_v  input  1  issue valid; marks iss_rd pending.
REQ-012 iss_rd  input  AW  destination register of the issuing instruction.
REQ-013 busy_a, busy_b  output  1 each  pending-write status of addr_a / addr_b.

Function
REQ-014 Register 0 SHALL read 0 on both ports; writes and issues to address 0 ignored; busy for address 0 always 0.
REQ-015 Write: on rising clk with we=1, addr_d!=0, addr_d<NREG -> reg[addr_d] <= data_d; else no register change.
REQ-016 Reads SHALL be combinational, zero-latency: data_x = reg[addr_x]; address >= NREG reads 0.
REQ-017 Scoreboard: one busy bit per register, no busy bit for x0; rising clk with iss_v=1, iss_rd!=0, iss_rd<NREG sets busy[iss_rd].
REQ-018 Rising clk with we=1 and valid addr_d clears busy[addr_d].
REQ-019 Same-edge set and clear of the same address: set wins, busy stays 1 (issue newer than writeback).
REQ-020 Same-edge set and clear of different addresses: both take effect.
REQ-021 busy_x = busy[addr_x], combinational; address >= NREG reports 0.
REQ-022 Both read ports SHALL be independent; addr_a==addr_b returns identical data and busy.
REQ-023 Scoreboard SHALL not gate writes: a write to a non-busy register still updates the register.

Reset
REQ-024 rst=0 SHALL asynchronously clear all registers and all busy bits, no clock needed.
REQ-025 While rst=0: data_a=data_b=0, busy_a=busy_b=0, writes and issues ignored.
REQ-026 After rst rises, first write/issue effective on the first rising clk with rst=1.
REQ-027 Reset asserted mid-sequence SHALL discard pending writes and issues at once; no partial update.

Configuration
REQ-028 Macro RV_REGFILE_BYPASS_EN.
REQ-029 Defined: we=1, addr_d!=0, addr_d==addr_x -> data_x=data_d and busy_x=0 in the same cycle, unless iss_v=1 with iss_rd==addr_x (then busy_x=1); x0 never bypassed.
REQ-030 Not defined: same-cycle read of a written address returns the old value and old busy; new values visible from the next cycle.

Verification
REQ-031 Reset: rst=0 with any inputs -> all data/busy outputs 0; after release, read x1..x31 -> 0.
REQ-032 Write/read: we=1, addr_d=5, data_d=0xDEADBEEF; next cycle addr_a=5 -> data_a=0xDEADBEEF; write addr_d=0 data 0x1 -> data_a(addr 0)=0.
REQ-033 Scoreboard: iss_v=1, iss_rd=7 -> busy_a(addr 7)=1 next cycle; we=1, addr_d=7 -> busy_a=0 after that edge.
REQ-034 Collision: busy[9]=1, same edge iss_rd=9 and we addr_d=9 -> busy[9]=1 and reg[9]=data_d.
REQ-035 Bypass (macro on): reg[3]=0x11, we=1, addr_d=3, data_d=0x22, addr_a=3 -> data_a=0x22 same cycle; macro off -> 0x11, then 0x22 next cycle.
REQ-036 Async reset mid-write: rst falls between edges with we=1 -> outputs 0 immediately; after release, reg[addr_d] reads 0.
